// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-ported, multi-cycle memory between instruction
// fetch and MEM-stage loads/stores. Data accesses take priority, and an access
// in flight is never pre-empted.
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifReq,
  input  logic [AW-1:0] ifAddr,
  input  logic          MemReadIn,
  input  logic          MemWriteIn,
  input  logic [AW-1:0] memAddr,
  input  logic [DW-1:0] memWriteData,
  input  logic          HaltIn,
  input  logic [DW-1:0] mRdData,
  output logic          mEnable,
  output logic          mWr,
  output logic [AW-1:0] mAddr,
  output logic [DW-1:0] mWrData,
  output logic [DW-1:0] instrOut,
  output logic          instrValid,
  output logic [DW-1:0] dataOut,
  output logic          dataValid,
  output logic          stallFetch,
  output logic          stallMem,
  output logic          controlZeroExMem,
  output logic          halted
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, HALTED} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          data_req;
  logic          last_cycle;

  assign data_req   = MemReadIn | MemWriteIn;
  assign last_cycle = (cnt == CW'(MEM_LAT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (data_req)    next_state = DATA;
        else if (HaltIn) next_state = HALTED;
        else if (ifReq)  next_state = FETCH;
      end
      FETCH, DATA: if (last_cycle) next_state = IDLE;
      HALTED:      next_state = HALTED;
      default:     next_state = IDLE;
    endcase
  end

  // Access latches, latency counter and completion registers.
  // Requests are sampled only at the IDLE grant edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      mWr        <= 1'b0;
      mAddr      <= '0;
      mWrData    <= '0;
      instrOut   <= '0;
      instrValid <= 1'b0;
      dataOut    <= '0;
      dataValid  <= 1'b0;
    end else begin
      instrValid <= 1'b0;
      dataValid  <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req) begin
            mAddr   <= memAddr;
            mWrData <= memWriteData;
            mWr     <= MemWriteIn;
            cnt     <= '0;
          end else if (!HaltIn && ifReq) begin
            mAddr <= ifAddr;
            mWr   <= 1'b0;
            cnt   <= '0;
          end
        end
        FETCH: begin
          cnt <= cnt + CW'(1);
          if (last_cycle) begin
            instrOut   <= mRdData;
            instrValid <= 1'b1;
          end
        end
        DATA: begin
          cnt <= cnt + CW'(1);
          if (last_cycle) begin
            if (!mWr) dataOut <= mRdData;
            dataValid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stalls are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    mEnable          = (state == FETCH) || (state == DATA);
    halted           = (state == HALTED);
    stallMem         = 1'b0;
    stallFetch       = 1'b0;
    if (rst) begin
      if (state == HALTED) begin
        stallFetch = ifReq;
      end else begin
        stallMem   = data_req & ~dataValid;
        stallFetch = (ifReq & ~instrValid) | stallMem;
      end
    end
    controlZeroExMem = stallMem;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=2): a cycle-by-cycle vector table
// followed by hand-written reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifReq = 1'b0;
  logic [15:0] ifAddr = '0;
  logic        MemReadIn = 1'b0;
  logic        MemWriteIn = 1'b0;
  logic [15:0] memAddr = '0;
  logic [15:0] memWriteData = '0;
  logic        HaltIn = 1'b0;
  logic [15:0] mRdData = '0;
  logic        mEnable, mWr, instrValid, dataValid;
  logic        stallFetch, stallMem, controlZeroExMem, halted;
  logic [15:0] mAddr, mWrData, instrOut, dataOut;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(2), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .memAddr(memAddr), .memWriteData(memWriteData),
    .HaltIn(HaltIn), .mRdData(mRdData),
    .mEnable(mEnable), .mWr(mWr), .mAddr(mAddr), .mWrData(mWrData),
    .instrOut(instrOut), .instrValid(instrValid),
    .dataOut(dataOut), .dataValid(dataValid),
    .stallFetch(stallFetch), .stallMem(stallMem),
    .controlZeroExMem(controlZeroExMem), .halted(halted)
  );

  // ctrl = {mEnable, instrValid, dataValid, stallFetch, stallMem, controlZeroExMem, halted}
  typedef struct {
    logic        if_req;
    logic [15:0] if_addr;
    logic        rd;
    logic        wr;
    logic [15:0] mem_addr;
    logic [15:0] wdata;
    logic        halt;
    logic [15:0] rdata;
    logic [6:0]  ctrl;
    logic [15:0] e_addr;
    logic        e_wr;
    logic [15:0] e_wdata;
    logic [15:0] e_instr;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic if_req, input logic [15:0] if_addr,
                              input logic rd, input logic wr,
                              input logic [15:0] mem_addr, input logic [15:0] wdata,
                              input logic halt, input logic [15:0] rdata,
                              input logic [6:0] ctrl, input logic [15:0] e_addr,
                              input logic e_wr, input logic [15:0] e_wdata,
                              input logic [15:0] e_instr, input logic [15:0] e_data);
    vec_t v;
    v.if_req = if_req; v.if_addr = if_addr; v.rd = rd; v.wr = wr;
    v.mem_addr = mem_addr; v.wdata = wdata; v.halt = halt; v.rdata = rdata;
    v.ctrl = ctrl; v.e_addr = e_addr; v.e_wr = e_wr; v.e_wdata = e_wdata;
    v.e_instr = e_instr; v.e_data = e_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_now();
    return {mEnable, instrValid, dataValid, stallFetch, stallMem, controlZeroExMem, halted};
  endfunction

  initial begin
    // fetch only
    vecs.push_back(mk(1,'h0010,0,0,'h0000,'h0000,0,'h0000, 7'b0001000,'h0000,0,'h0000,'h0000,'h0000));
    vecs.push_back(mk(1,'h0010,0,0,'h0000,'h0000,0,'hA5A5, 7'b1001000,'h0010,0,'h0000,'h0000,'h0000));
    vecs.push_back(mk(1,'h0010,0,0,'h0000,'h0000,0,'hA5A5, 7'b1001000,'h0010,0,'h0000,'h0000,'h0000));
    vecs.push_back(mk(0,'h0000,0,0,'h0000,'h0000,0,'h0000, 7'b0100000,'h0000,0,'h0000,'hA5A5,'h0000));
    // fetch and load in the same cycle: load first
    vecs.push_back(mk(1,'h0020,1,0,'h0200,'h0000,0,'h0000, 7'b0001110,'h0000,0,'h0000,'hA5A5,'h0000));
    vecs.push_back(mk(1,'h0020,1,0,'h0200,'h0000,0,'h1234, 7'b1001110,'h0200,0,'h0000,'hA5A5,'h0000));
    vecs.push_back(mk(1,'h0020,1,0,'h0200,'h0000,0,'h1234, 7'b1001110,'h0200,0,'h0000,'hA5A5,'h0000));
    vecs.push_back(mk(1,'h0020,0,0,'h0000,'h0000,0,'h0000, 7'b0011000,'h0000,0,'h0000,'hA5A5,'h1234));
    vecs.push_back(mk(1,'h0020,0,0,'h0000,'h0000,0,'h5678, 7'b1001000,'h0020,0,'h0000,'hA5A5,'h1234));
    vecs.push_back(mk(1,'h0020,0,0,'h0000,'h0000,0,'h5678, 7'b1001000,'h0020,0,'h0000,'hA5A5,'h1234));
    vecs.push_back(mk(0,'h0000,0,0,'h0000,'h0000,0,'h0000, 7'b0100000,'h0000,0,'h0000,'h5678,'h1234));
    // store: dataOut must keep 0x1234
    vecs.push_back(mk(0,'h0000,0,1,'h0300,'hBEEF,0,'h0000, 7'b0001110,'h0000,0,'h0000,'h5678,'h1234));
    vecs.push_back(mk(0,'h0000,0,1,'h0300,'hBEEF,0,'hDEAD, 7'b1001110,'h0300,1,'hBEEF,'h5678,'h1234));
    vecs.push_back(mk(0,'h0000,0,1,'h0300,'hBEEF,0,'hDEAD, 7'b1001110,'h0300,1,'hBEEF,'h5678,'h1234));
    vecs.push_back(mk(0,'h0000,0,0,'h0000,'h0000,0,'h0000, 7'b0010000,'h0000,0,'h0000,'h5678,'h1234));
    // load arriving during a fetch waits
    vecs.push_back(mk(1,'h0040,0,0,'h0000,'h0000,0,'h0000, 7'b0001000,'h0000,0,'h0000,'h5678,'h1234));
    vecs.push_back(mk(1,'h0040,1,0,'h0400,'h0000,0,'h1111, 7'b1001110,'h0040,0,'h0000,'h5678,'h1234));
    vecs.push_back(mk(1,'h0040,1,0,'h0400,'h0000,0,'h1111, 7'b1001110,'h0040,0,'h0000,'h5678,'h1234));
    vecs.push_back(mk(0,'h0000,1,0,'h0400,'h0000,0,'h0000, 7'b0101110,'h0000,0,'h0000,'h1111,'h1234));
    vecs.push_back(mk(0,'h0000,1,0,'h0400,'h0000,0,'h2222, 7'b1001110,'h0400,0,'h0000,'h1111,'h1234));
    vecs.push_back(mk(0,'h0000,1,0,'h0400,'h0000,0,'h2222, 7'b1001110,'h0400,0,'h0000,'h1111,'h1234));
    vecs.push_back(mk(0,'h0000,0,0,'h0000,'h0000,0,'h0000, 7'b0010000,'h0000,0,'h0000,'h1111,'h2222));
    // halt during a fetch
    vecs.push_back(mk(1,'h0050,0,0,'h0000,'h0000,0,'h0000, 7'b0001000,'h0000,0,'h0000,'h1111,'h2222));
    vecs.push_back(mk(1,'h0050,0,0,'h0000,'h0000,1,'h3333, 7'b1001000,'h0050,0,'h0000,'h1111,'h2222));
    vecs.push_back(mk(1,'h0050,0,0,'h0000,'h0000,1,'h3333, 7'b1001000,'h0050,0,'h0000,'h1111,'h2222));
    vecs.push_back(mk(0,'h0000,0,0,'h0000,'h0000,1,'h0000, 7'b0100000,'h0000,0,'h0000,'h3333,'h2222));
    vecs.push_back(mk(1,'h0060,0,0,'h0000,'h0000,1,'h0000, 7'b0001001,'h0000,0,'h0000,'h3333,'h2222));
    vecs.push_back(mk(1,'h0060,1,0,'h0600,'h0000,1,'h0000, 7'b0001001,'h0000,0,'h0000,'h3333,'h2222));
    vecs.push_back(mk(0,'h0000,0,0,'h0000,'h0000,0,'h0000, 7'b0000001,'h0000,0,'h0000,'h3333,'h2222));

    // reset state
    #2;
    check("reset_ctrl", 32'(ctrl_now()), 32'h0);
    check("reset_mwr_maddr", {15'h0, mWr, mAddr}, 32'h0);
    check("reset_outs", {instrOut, dataOut}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      ifReq = vecs[i].if_req;   ifAddr = vecs[i].if_addr;
      MemReadIn = vecs[i].rd;   MemWriteIn = vecs[i].wr;
      memAddr = vecs[i].mem_addr; memWriteData = vecs[i].wdata;
      HaltIn = vecs[i].halt;    mRdData = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("row%0d_ctrl", i), 32'(ctrl_now()), 32'(vecs[i].ctrl));
      check($sformatf("row%0d_instrOut", i), 32'(instrOut), 32'(vecs[i].e_instr));
      check($sformatf("row%0d_dataOut", i), 32'(dataOut), 32'(vecs[i].e_data));
      if (vecs[i].ctrl[6]) begin
        check($sformatf("row%0d_mAddr", i), 32'(mAddr), 32'(vecs[i].e_addr));
        check($sformatf("row%0d_mWr", i), 32'(mWr), 32'(vecs[i].e_wr));
        if (vecs[i].e_wr)
          check($sformatf("row%0d_mWrData", i), 32'(mWrData), 32'(vecs[i].e_wdata));
      end
    end

    // reset out of HALTED clears registered outputs
    rst = 1'b0;
    #1;
    check("halt_reset_ctrl", 32'(ctrl_now()), 32'h0);
    check("halt_reset_outs", {instrOut, dataOut}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // store interrupted by reset in its first access cycle
    @(posedge clk); #1;
    MemWriteIn = 1'b1; memAddr = 16'h0500; memWriteData = 16'hCAFE;
    @(posedge clk); #1;
    @(negedge clk);
    check("midacc_pre_ctrl", 32'(ctrl_now()), 32'b1001110);
    check("midacc_pre_bus", {mWr, mAddr}, {16'h0, 1'b1, 16'h0500});
    #2;
    rst = 1'b0;
    #1;
    check("midacc_rst_ctrl", 32'(ctrl_now()), 32'h0);
    check("midacc_rst_bus", {mWr, mAddr}, 32'h0);
    check("midacc_rst_wdata", 32'(mWrData), 32'h0);
    MemWriteIn = 1'b0; memAddr = '0; memWriteData = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abandoned_%0d", k), 32'(ctrl_now()), 32'h0);
    end

    // fresh fetch after reset: valid pulse three cycles after the request
    @(posedge clk); #1;
    ifReq = 1'b1; ifAddr = 16'h0070; mRdData = 16'h7777;
    @(negedge clk);
    check("post_fetch_c0", 32'(ctrl_now()), 32'b0001000);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check($sformatf("post_fetch_c%0d", k), 32'(ctrl_now()), 32'b1001000);
      check($sformatf("post_fetch_addr%0d", k), 32'(mAddr), 32'h0070);
    end
    @(posedge clk); #1;
    ifReq = 1'b0;
    @(negedge clk);
    check("post_fetch_c3", 32'(ctrl_now()), 32'b0100000);
    check("post_fetch_instr", 32'(instrOut), 32'h7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, multi-cycle unified memory between the fetch stage (instruction reads) and the MEM stage (data loads/stores).
- Sequences each access with an FSM and a latency counter.
- Raises stall signals toward the fetch stage and the MEM stage.
- Drives controlZeroExMem so the EX/MEM register inserts a bubble while a data access is outstanding.

Parameters:
- MEM_LAT, 2: cycles the memory needs per access (>=1); read data is valid in the last access cycle.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ifReq  in  1  fetch requests an instruction read.
- ifAddr  in  AW  fetch address.
- MemReadIn  in  1  MEM stage load request.
- MemWriteIn  in  1  MEM stage store request.
- memAddr  in  AW  data address.
- memWriteData  in  DW  store data.
- HaltIn  in  1  halt instruction has reached MEM.
- mRdData  in  DW  read data from the memory macro.
- mEnable  out  1  memory access active.
- mWr  out  1  1 = write, 0 = read; valid only while mEnable=1.
- mAddr  out  AW  latched access address.
- mWrData  out  DW  latched store data.
- instrOut  out  DW  fetched instruction.
- instrValid  out  1  one-cycle completion pulse for a fetch.
- dataOut  out  DW  load result.
- dataValid  out  1  one-cycle completion pulse for a load or store.
- stallFetch  out  1  hold PC and the IF/ID register.
- stallMem  out  1  hold the MEM stage and everything upstream.
- controlZeroExMem  out  1  zero the EX/MEM control bits this cycle.
- halted  out  1  arbiter has halted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0.
  - All outputs 0, including mEnable, mWr, mAddr, mWrData, instrOut, dataOut.
  - mEnable drops immediately, even mid-access; the access is abandoned with no completion pulse.
- States: IDLE, FETCH, DATA, HALTED. cnt is ceil(log2(MEM_LAT+1)) bits wide.
- IDLE, priority order at each edge:
  - dataReq = MemReadIn|MemWriteIn. If dataReq: go to DATA. Latch memAddr→mAddr, memWriteData→mWrData, MemWriteIn→mWr. Set cnt=0.
  - else if HaltIn: go to HALTED.
  - else if ifReq: go to FETCH. Latch ifAddr→mAddr, set mWr=0, cnt=0.
  - Data always beats fetch when both request in the same cycle.
- FETCH/DATA:
  - mEnable=1.
  - cnt increments each edge.
  - At the edge where cnt==MEM_LAT-1: register mRdData into instrOut (FETCH) or dataOut (DATA read only; a store leaves dataOut unchanged). Pulse instrValid or dataValid high for exactly the next cycle. Return to IDLE.
- An in-flight access is never pre-empted. A data request arriving during FETCH waits for the fetch to complete.
- Latency: request seen in IDLE at cycle T → valid pulse in cycle T+1+MEM_LAT. Back-to-back accesses therefore take MEM_LAT+1 cycles each.
- Requesters hold request, address and data stable until their valid pulse. Inputs are sampled only at the IDLE grant edge.
- Stalls (combinational):
  - stallMem = dataReq & ~dataValid.
  - stallFetch = (ifReq & ~instrValid) | stallMem.
  - controlZeroExMem = stallMem.
  - During HALTED: stallFetch = ifReq; stallMem = 0.
- HALTED:
  - Entered only from IDLE with no data request pending.
  - Terminal until reset; mEnable stays 0 and halted=1.
  - A halt arriving mid-access takes effect only after that access completes.
- Simultaneous completion and new request: none. Completion always returns to IDLE, and the new grant occurs on the following edge.
- MemReadIn and MemWriteIn both high is treated as a write.
- MEM_LAT=1: each access state lasts one cycle; the valid pulse appears 2 cycles after the request.

Test Plan:
1. Fetch only, MEM_LAT=2: ifReq=1, ifAddr=0x0010, mRdData=0xA5A5 during access. → mEnable high for cycles 1-2 with mAddr=0x0010 and mWr=0; instrValid pulse in cycle 3 with instrOut=0xA5A5; stallFetch=1 for cycles 0-2, then 0.
2. Conflict: ifReq and MemReadIn both raised in cycle 0 (memAddr=0x0200, mRdData=0x1234). → DATA served first, dataValid in cycle 3 with dataOut=0x1234; fetch granted at the cycle-3 edge, instrValid in cycle 6; controlZeroExMem=1 for cycles 0-2.
3. Store: MemWriteIn=1, memAddr=0x0300, memWriteData=0xBEEF. → mWr=1, mAddr=0x0300, mWrData=0xBEEF while mEnable=1; dataValid pulses; dataOut keeps its previous value.
4. Data request during fetch: MemReadIn rises in cycle 1 of a FETCH. → fetch completes undisturbed; DATA begins after return to IDLE; stallMem=1 throughout the wait.
5. Halt: HaltIn=1 during an active FETCH. → fetch completes, then HALTED; halted=1; later ifReq gives stallFetch=1 and mEnable stays 0.
6. Reset mid-access: rst=0 in cycle 1 of DATA. → mEnable and all outputs 0 asynchronously; after rst=1, a fresh ifReq completes normally with MEM_LAT+1 latency.
